// File: rtl/nand4_pkg.sv
// Shared definitions for the NAND4 stimulus/checker: FSM encodings and pattern geometry.
package nand4_pkg;

    localparam int NUM_PATTERNS = 16;
    localparam int PAT_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/nand4_stim_checker_hold_timer.sv
// Hold-window timer: counts 0..HOLD_CYCLES-1 while enabled and pulses expire on the last count.
module hold_timer #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_expire = i_enable && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = o_expire ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nand4_stim_checker.sv
// Sweeps all 16 NAND4 input patterns, samples the gate at the end of each hold window
// and accumulates a mismatch count with a start/done handshake.
module nand4_stim_checker
    import nand4_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_f,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_err_cnt,
    output logic       o_err_flag
);

    generate
        if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
            $fatal(1, "nand4_stim_checker: HOLD_CYCLES must be in 2..255");
        end
        if ((2 ** CNT_W) <= HOLD_CYCLES) begin : g_bad_cnt_w
            $fatal(1, "nand4_stim_checker: CNT_W too narrow for HOLD_CYCLES");
        end
    endgenerate

    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [4:0]       err_cnt_q;
    logic             err_flag_q;
    logic             busy_q;
    logic             done_q;

    logic timer_expire;
    logic mismatch;

    // Counter is held at zero outside DRIVE so every sweep starts a fresh window.
    hold_timer #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (state_q != DRIVE),
        .i_enable (state_q == DRIVE),
        .o_expire (timer_expire)
    );

    assign mismatch = (i_f != ~(&pat_q));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        state_q    <= DRIVE;
                        pat_q      <= '0;
                        err_cnt_q  <= '0;
                        err_flag_q <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (timer_expire) begin
                        if (mismatch) begin
                            err_cnt_q  <= err_cnt_q + 5'd1;
                            err_flag_q <= 1'b1;
                        end
                        // Pattern stays at 1111 after the last window so DONE drives all ones.
                        if (pat_q == LAST_PAT) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pat_q <= pat_q + PAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    pat_q      <= '0;
                    err_cnt_q  <= '0;
                    err_flag_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign {o_a, o_b, o_c, o_d} = pat_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_err_flag = err_flag_q;

endmodule

// File: tb/tb_nand4_stim_checker.sv
// Self-checking bench: table of gate faults plus random fault masks, reset/start corner cases, HOLD_CYCLES=2.
module tb_nand4_stim_checker;

    localparam int H  = 4;
    localparam int H2 = 2;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_f;
    logic       o_a, o_b, o_c, o_d, o_busy, o_done, o_err_flag;
    logic [4:0] o_err_cnt;

    logic       start2;
    logic       f2;
    logic       a2, b2, c2, d2, busy2, done2, flag2;
    logic [4:0] err2;

    int          total = 0;
    int          bad   = 0;
    int          mode  = 0;
    logic [15:0] mask  = '0;
    logic [3:0]  pat, pat2;

    nand4_stim_checker #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_f(i_f),
        .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d),
        .o_busy(o_busy), .o_done(o_done), .o_err_cnt(o_err_cnt), .o_err_flag(o_err_flag)
    );

    nand4_stim_checker #(.HOLD_CYCLES(H2), .CNT_W(8)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_f(f2),
        .o_a(a2), .o_b(b2), .o_c(c2), .o_d(d2),
        .o_busy(busy2), .o_done(done2), .o_err_cnt(err2), .o_err_flag(flag2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pat  = {o_a, o_b, o_c, o_d};
    assign pat2 = {a2, b2, c2, d2};
    assign f2   = ~(&pat2);

    // Gate under test: 0 correct, 1 stuck-at-1, 2 inverted (AND), 3 correct with per-pattern flips.
    always_comb begin
        i_f = ~(&pat);
        case (mode)
            1:       i_f = 1'b1;
            2:       i_f = &pat;
            3:       i_f = (~(&pat)) ^ mask[pat];
            default: i_f = ~(&pat);
        endcase
    end

    function automatic int model_errs(input int m, input logic [15:0] msk);
        int n = 0;
        for (int p = 0; p < 16; p++) begin
            bit good = (p != 15);
            bit got;
            case (m)
                1:       got = 1'b1;
                2:       got = !good;
                3:       got = good ^ msk[p];
                default: got = good;
            endcase
            if (got != good) n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call #1 after a posedge with i_start low. Returns cycles from start edge to o_done.
    task automatic run_sweep(input int pulse_at, output int done_k, output int walk_bad,
                             output int clr_ok);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        clr_ok   = (o_err_cnt == 5'd0 && !o_err_flag && !o_done && o_busy) ? 1 : 0;
        done_k   = -1;
        walk_bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (o_done) begin
                done_k = k;
                break;
            end
            if (!o_busy || int'(pat) != k / H) walk_bad++;
            i_start = (k == pulse_at);
            tick();
        end
        i_start = 1'b0;
    endtask

    typedef struct {
        int          mode;
        logic [15:0] mask;
        int          exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int dk, wb, ck;
        rst_n   = 1'b0;
        i_start = 1'b0;
        start2  = 1'b0;

        tbl[0] = '{0, 16'h0000, 0};
        tbl[1] = '{1, 16'h0000, 1};
        tbl[2] = '{2, 16'h0000, 16};
        tbl[3] = '{3, 16'h8001, 2};
        for (int i = 4; i < 8; i++) begin
            tbl[i].mode    = 3;
            tbl[i].mask    = 16'($urandom);
            tbl[i].exp_err = model_errs(3, tbl[i].mask);
        end

        tick();
        tick();
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_err_cnt", int'(o_err_cnt), 0);
        chk("reset_err_flag", int'(o_err_flag), 0);
        chk("reset_pattern", int'(pat), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_start_busy", int'(o_busy), 0);

        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode;
            mask = tbl[i].mask;
            run_sweep(-1, dk, wb, ck);
            $display("vec %0d mode=%0d mask=%04h done_at=%0d err=%0d exp_err=%0d",
                     i, mode, mask, dk, o_err_cnt, tbl[i].exp_err);
            chk("vec_start_clear", ck, 1);
            chk("vec_done_latency", dk, 16 * H);
            chk("vec_walk", wb, 0);
            chk("vec_err_cnt", int'(o_err_cnt), tbl[i].exp_err);
            chk("vec_err_flag", int'(o_err_flag), int'(tbl[i].exp_err != 0));
            chk("vec_done_pattern", int'(pat), 15);
            chk("vec_done_busy", int'(o_busy), 0);
            tick();
        end

        // Start pulsed mid-sweep must be ignored; start in DONE (previous sweep had errors) clears.
        mode = 0;
        run_sweep(10, dk, wb, ck);
        $display("start_in_drive done_at=%0d err=%0d", dk, o_err_cnt);
        chk("start_in_done_clear", ck, 1);
        chk("start_in_drive_latency", dk, 16 * H);
        chk("start_in_drive_walk", wb, 0);
        chk("start_in_drive_err", int'(o_err_cnt), 0);

        // Randomized fault masks against the reference model.
        for (int r = 0; r < 5; r++) begin
            int e;
            mode = 3;
            mask = 16'($urandom);
            e    = model_errs(3, mask);
            run_sweep(int'($urandom_range(0, 60)), dk, wb, ck);
            $display("rand %0d mask=%04h done_at=%0d err=%0d exp_err=%0d", r, mask, dk, o_err_cnt, e);
            chk("rand_latency", dk, 16 * H);
            chk("rand_err_cnt", int'(o_err_cnt), e);
            chk("rand_err_flag", int'(o_err_flag), int'(e != 0));
        end

        // Mid-sweep asynchronous reset.
        mode    = 1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        $display("async_reset busy=%0d pat=%0d err=%0d", o_busy, pat, o_err_cnt);
        chk("async_rst_busy", int'(o_busy), 0);
        chk("async_rst_pattern", int'(pat), 0);
        chk("async_rst_done_flag", int'({o_done, o_err_flag}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("after_rst_idle", int'({o_busy, o_done, pat}), 0);
        mode = 0;
        run_sweep(-1, dk, wb, ck);
        $display("post_reset sweep done_at=%0d err=%0d", dk, o_err_cnt);
        chk("post_rst_latency", dk, 16 * H);
        chk("post_rst_err", int'(o_err_cnt), 0);
        chk("post_rst_walk", wb, 0);

        // Start held high: exactly one DONE cycle between back-to-back sweeps.
        tick();
        i_start = 1'b1;
        tick();
        dk = -1;
        for (int k = 0; k < 200; k++) begin
            if (o_done) begin
                dk = k;
                break;
            end
            tick();
        end
        chk("b2b_first_latency", dk, 16 * H);
        tick();
        $display("back_to_back busy=%0d done=%0d pat=%0d", o_busy, o_done, pat);
        chk("b2b_restart_busy", int'(o_busy), 1);
        chk("b2b_restart_done", int'(o_done), 0);
        i_start = 1'b0;

        // HOLD_CYCLES=2 instance with a correct gate.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        dk = -1;
        wb = 0;
        for (int k = 0; k < 200; k++) begin
            if (done2) begin
                dk = k;
                break;
            end
            if (!busy2 || int'(pat2) != k / H2) wb++;
            tick();
        end
        $display("hold2 done_at=%0d err=%0d", dk, err2);
        chk("hold2_latency", dk, 16 * H2);
        chk("hold2_walk", wb, 0);
        chk("hold2_err", int'({flag2, err2}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
